// File: rtl/aq_djpeg_pkg.sv
// Shared JPEG decoder back-end types: sample type, chroma subsampling mode and
// fixed-point coefficient helper.
package aq_djpeg_pkg;

    typedef logic signed [8:0] sample_t;

    // Bit 0: two luma blocks across, bit 1: two luma blocks down.
    typedef enum logic [1:0] {
        SS_444 = 2'b00,
        SS_422 = 2'b01,
        SS_440 = 2'b10,
        SS_420 = 2'b11
    } ssMode_e;

    function automatic int coefConst(input real c, input int frac);
        return $rtoi(c * real'(longint'(1) << frac) + 0.5);
    endfunction

    function automatic ssMode_e ssModeOf(input logic [1:0] w, input logic [1:0] h);
        return ssMode_e'({h == 2'd2, w == 2'd2});
    endfunction

endpackage

// File: rtl/aq_djpeg_ycbcr2rgb_px_cc_mac.sv
// One colour channel: Y base plus two weighted chroma products, summed,
// rounded and saturated into the output register.
module aq_djpeg_cc_mac
    import aq_djpeg_pkg::*;
#(
    parameter int COEF_FRAC = 14,
    parameter int OUT_BITS  = 8,
    parameter int COEF_CB   = 0,
    parameter int COEF_CR   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  sample_t             yIn,
    input  sample_t             cbIn,
    input  sample_t             crIn,
    output logic [OUT_BITS-1:0] chanOut
);

    localparam int ACC_W = 10 + COEF_FRAC + 3;
    localparam logic signed [ACC_W-1:0] K_CB    = ACC_W'(COEF_CB);
    localparam logic signed [ACC_W-1:0] K_CR    = ACC_W'(COEF_CR);
    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(64'd1 << (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] MAX_OUT = ACC_W'((64'd1 << OUT_BITS) - 1);

    logic signed [ACC_W-1:0] yBase_p2, prodCb_p2, prodCr_p2;
    logic signed [ACC_W-1:0] sum_p3;

    function automatic logic [OUT_BITS-1:0] roundSat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] q;
        q = (acc + HALF) >>> COEF_FRAC;
        if (q[ACC_W-1]) return '0;
        if (q > MAX_OUT) return '1;
        return q[OUT_BITS-1:0];
    endfunction

    // S2 products, S3 sum
    always_ff @(posedge clk) begin
        if (adv) begin
            yBase_p2  <= (ACC_W'(yIn) + ACC_W'(128)) <<< COEF_FRAC;
            prodCb_p2 <= ACC_W'(cbIn) * K_CB;
            prodCr_p2 <= ACC_W'(crIn) * K_CR;
            sum_p3    <= yBase_p2 + prodCb_p2 + prodCr_p2;
        end
    end

    // S4 output register
    always_ff @(posedge clk) begin
        if (rst) begin
            chanOut <= '0;
        end else if (adv) begin
            chanOut <= roundSat(sum_p3);
        end
    end

endmodule

// File: rtl/aq_djpeg_ycbcr2rgb_px.sv
// YCbCr to RGB converter: walks one MCU per start pulse, issues buffer addresses
// and pushes clipped, converted pixels through a 4-deep stallable pipeline.
module aq_djpeg_ycbcr2rgb_px
    import aq_djpeg_pkg::*;
#(
    parameter int BLK_W     = 12,
    parameter int PIX_W     = 16,
    parameter int COEF_FRAC = 14,
    parameter int OUT_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                InEnable,
    input  logic [BLK_W-1:0]    InBlockX,
    input  logic [BLK_W-1:0]    InBlockY,
    input  logic [1:0]          SubSamplingW,
    input  logic [1:0]          SubSamplingH,
    input  logic                InGray,
    input  logic [PIX_W-1:0]    ImageWidth,
    input  logic [PIX_W-1:0]    ImageHeight,
    output logic                InRead,
    output logic                InReadNext,
    output logic [7:0]          InAddressY,
    output logic [5:0]          InAddressCbCr,
    input  logic signed [8:0]   InY,
    input  logic signed [8:0]   InCb,
    input  logic signed [8:0]   InCr,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [PIX_W-1:0]    OutPixelX,
    output logic [PIX_W-1:0]    OutPixelY,
    output logic [OUT_BITS-1:0] OutR,
    output logic [OUT_BITS-1:0] OutG,
    output logic [OUT_BITS-1:0] OutB
);

    localparam int K_CR_R = coefConst(1.402, COEF_FRAC);
    localparam int K_CB_G = coefConst(0.34414, COEF_FRAC);
    localparam int K_CR_G = coefConst(0.71414, COEF_FRAC);
    localparam int K_CB_B = coefConst(1.772, COEF_FRAC);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state, stateNext;
    logic [BLK_W-1:0] blkX, blkY;
    ssMode_e          mode;
    logic             gray;
    logic [3:0]       px, py;
    logic             wide, tall, adv, lastPix, inImage;
    logic [3:0]       pxMax, pyMax;
    logic [PIX_W-1:0] pixX, pixY;

    logic             vld_p1, vld_p2, vld_p3;
    logic             gray_p1;
    logic [PIX_W-1:0] x_p1, y_p1, x_p2, y_p2, x_p3, y_p3;
    sample_t          cbS1, crS1;

    assign wide    = (mode == SS_422) || (mode == SS_420);
    assign tall    = (mode == SS_440) || (mode == SS_420);
    assign pxMax   = wide ? 4'd15 : 4'd7;
    assign pyMax   = tall ? 4'd15 : 4'd7;
    assign adv     = !OutValid || OutReady;
    assign lastPix = (px == pxMax) && (py == pyMax);

    assign InRead        = (state == RUN) && adv;
    assign InReadNext    = InRead && lastPix;
    assign InAddressY    = {py, px};
    assign InAddressCbCr = {tall ? py[3:1] : py[2:0], wide ? px[3:1] : px[2:0]};

    assign pixX    = (wide ? (PIX_W'(blkX) << 4) : (PIX_W'(blkX) << 3)) + PIX_W'(px);
    assign pixY    = (tall ? (PIX_W'(blkY) << 4) : (PIX_W'(blkY) << 3)) + PIX_W'(py);
    assign inImage = (pixX < ImageWidth) && (pixY < ImageHeight);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (InEnable) stateNext = RUN;
            RUN:     if (InReadNext) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // S0 address issue: MCU context latch and raster counter
    always_ff @(posedge clk) begin
        if (rst) begin
            px   <= '0;
            py   <= '0;
            blkX <= '0;
            blkY <= '0;
            mode <= SS_444;
            gray <= 1'b0;
        end else if (state == IDLE && InEnable) begin
            px   <= '0;
            py   <= '0;
            blkX <= InBlockX;
            blkY <= InBlockY;
            mode <= ssModeOf(SubSamplingW, SubSamplingH);
            gray <= InGray;
        end else if (InRead) begin
            px <= (px == pxMax) ? 4'd0 : px + 4'd1;
            if (px == pxMax) py <= py + 4'd1;
        end
    end

    // Valid bits walk with the data; edge pixels enter with valid cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            vld_p3   <= 1'b0;
            OutValid <= 1'b0;
        end else if (adv) begin
            vld_p1   <= InRead && inImage;
            vld_p2   <= vld_p1;
            vld_p3   <= vld_p2;
            OutValid <= vld_p3;
        end
    end

    // S1..S3 coordinates; S1 data is the buffer's own output register
    always_ff @(posedge clk) begin
        if (adv) begin
            x_p1    <= pixX;
            y_p1    <= pixY;
            gray_p1 <= gray;
            x_p2    <= x_p1;
            y_p2    <= y_p1;
            x_p3    <= x_p2;
            y_p3    <= y_p2;
        end
    end

    // S4 coordinates
    always_ff @(posedge clk) begin
        if (rst) begin
            OutPixelX <= '0;
            OutPixelY <= '0;
        end else if (adv) begin
            OutPixelX <= x_p3;
            OutPixelY <= y_p3;
        end
    end

    assign cbS1 = gray_p1 ? sample_t'(0) : InCb;
    assign crS1 = gray_p1 ? sample_t'(0) : InCr;

    aq_djpeg_cc_mac #(.COEF_FRAC(COEF_FRAC), .OUT_BITS(OUT_BITS),
                      .COEF_CB(0), .COEF_CR(K_CR_R)) uMacR (
        .clk(clk), .rst(rst), .adv(adv),
        .yIn(InY), .cbIn(cbS1), .crIn(crS1), .chanOut(OutR)
    );

    aq_djpeg_cc_mac #(.COEF_FRAC(COEF_FRAC), .OUT_BITS(OUT_BITS),
                      .COEF_CB(-K_CB_G), .COEF_CR(-K_CR_G)) uMacG (
        .clk(clk), .rst(rst), .adv(adv),
        .yIn(InY), .cbIn(cbS1), .crIn(crS1), .chanOut(OutG)
    );

    aq_djpeg_cc_mac #(.COEF_FRAC(COEF_FRAC), .OUT_BITS(OUT_BITS),
                      .COEF_CB(K_CB_B), .COEF_CR(0)) uMacB (
        .clk(clk), .rst(rst), .adv(adv),
        .yIn(InY), .cbIn(cbS1), .crIn(crS1), .chanOut(OutB)
    );

endmodule

// File: tb/tb_aq_djpeg_ycbcr2rgb_px.sv
// Randomised bench for the YCbCr to RGB MCU converter with a behavioural
// per-pixel colour model and a single per-cycle compare process.
module tb_aq_djpeg_ycbcr2rgb_px;

    localparam int BLK_W     = 12;
    localparam int PIX_W     = 16;
    localparam int COEF_FRAC = 14;
    localparam int OUT_BITS  = 8;

    typedef struct {
        int x;
        int y;
        int r;
        int g;
        int b;
    } pix_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  InEnable = 1'b0;
    logic [BLK_W-1:0]      InBlockX = '0;
    logic [BLK_W-1:0]      InBlockY = '0;
    logic [1:0]            SubSamplingW = 2'd1;
    logic [1:0]            SubSamplingH = 2'd1;
    logic                  InGray = 1'b0;
    logic [PIX_W-1:0]      ImageWidth = 16'd1000;
    logic [PIX_W-1:0]      ImageHeight = 16'd1000;
    logic                  InRead, InReadNext;
    logic [7:0]            InAddressY;
    logic [5:0]            InAddressCbCr;
    logic signed [8:0]     InY = '0;
    logic signed [8:0]     InCb = '0;
    logic signed [8:0]     InCr = '0;
    logic                  OutValid;
    logic                  OutReady = 1'b1;
    logic [PIX_W-1:0]      OutPixelX, OutPixelY;
    logic [OUT_BITS-1:0]   OutR, OutG, OutB;

    always #5 clk = ~clk;

    aq_djpeg_ycbcr2rgb_px #(
        .BLK_W(BLK_W), .PIX_W(PIX_W), .COEF_FRAC(COEF_FRAC), .OUT_BITS(OUT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .InEnable(InEnable),
        .InBlockX(InBlockX), .InBlockY(InBlockY),
        .SubSamplingW(SubSamplingW), .SubSamplingH(SubSamplingH),
        .InGray(InGray), .ImageWidth(ImageWidth), .ImageHeight(ImageHeight),
        .InRead(InRead), .InReadNext(InReadNext),
        .InAddressY(InAddressY), .InAddressCbCr(InAddressCbCr),
        .InY(InY), .InCb(InCb), .InCr(InCr),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutPixelX(OutPixelX), .OutPixelY(OutPixelY),
        .OutR(OutR), .OutG(OutG), .OutB(OutB)
    );

    // Sample buffers: registered read, output held while InRead is low
    logic signed [8:0] yMem [256];
    logic signed [8:0] cbMem [64];
    logic signed [8:0] crMem [64];

    always @(posedge clk) begin
        if (InRead) begin
            InY  <= yMem[InAddressY];
            InCb <= cbMem[InAddressCbCr];
            InCr <= crMem[InAddressCbCr];
        end
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   readIdx = 0;
    int   curN = 0, curW = 1, curH = 1;
    int   beatCnt = 0;
    int   firstReadCyc = 0, firstValidCyc = 0;
    bit   seenValid = 0;
    bit   randReady = 0;
    bit   prevStall = 0;
    longint heldVec = 0;
    int   addrYLog [256];
    int   addrCLog [256];
    pix_t expQ [$];
    pix_t beats [$];
    pix_t refBeats [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int rnd(input real c);
        return $rtoi(c * 16384.0 + 0.5);
    endfunction

    function automatic int sat8(input longint acc);
        longint q;
        q = (acc + 64'sd8192) >>> 14;
        if (q < 0) return 0;
        if (q > 255) return 255;
        return int'(q);
    endfunction

    function automatic pix_t modelPix(input int x, input int y, input int ys, input int cb, input int cr);
        pix_t   p;
        longint yb;
        yb  = longint'(ys + 128) * 16384;
        p.x = x;
        p.y = y;
        p.r = sat8(yb + longint'(rnd(1.402)) * cr);
        p.g = sat8(yb - longint'(rnd(0.34414)) * cb - longint'(rnd(0.71414)) * cr);
        p.b = sat8(yb + longint'(rnd(1.772)) * cb);
        return p;
    endfunction

    function automatic pix_t getBeat(input int idx);
        pix_t none;
        none = '{-1, -1, -1, -1, -1};
        if (idx < 0 || idx >= beats.size()) return none;
        return beats[idx];
    endfunction

    // Single compare process: addresses, handshake stability and output beats
    always @(negedge clk) begin
        OutReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (rst) begin
            prevStall = 0;
        end else begin
            if (prevStall)
                chk("stall hold", {OutValid, OutPixelX, OutPixelY, OutR, OutG, OutB}, heldVec);
            if (InRead) begin
                chk("read within MCU", readIdx < curN, 1);
                if (readIdx < curN) begin
                    int epx, epy;
                    epx = readIdx % (8 * curW);
                    epy = readIdx / (8 * curW);
                    chk("addr Y", InAddressY, epy * 16 + epx);
                    chk("addr CbCr", InAddressCbCr, (epy >> (curH - 1)) * 8 + (epx >> (curW - 1)));
                    chk("InReadNext", InReadNext, readIdx == curN - 1);
                    addrYLog[readIdx] = InAddressY;
                    addrCLog[readIdx] = InAddressCbCr;
                    if (readIdx == 0) firstReadCyc = cyc;
                end
                readIdx++;
            end else begin
                chk("InReadNext without read", InReadNext, 0);
            end
            if (OutValid && !seenValid) begin
                seenValid     = 1;
                firstValidCyc = cyc;
            end
            if (OutValid && OutReady) begin
                pix_t a, e;
                a = '{int'(OutPixelX), int'(OutPixelY), int'(OutR), int'(OutG), int'(OutB)};
                beats.push_back(a);
                beatCnt++;
                chk("beat expected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    chk("pix X", a.x, e.x);
                    chk("pix Y", a.y, e.y);
                    chk("pix R", a.r, e.r);
                    chk("pix G", a.g, e.g);
                    chk("pix B", a.b, e.b);
                end
            end
            prevStall = OutValid && !OutReady;
            heldVec   = {OutValid, OutPixelX, OutPixelY, OutR, OutG, OutB};
        end
    end

    task automatic fillConst(input int y, input int cb, input int cr);
        for (int i = 0; i < 256; i++) yMem[i] = 9'(y);
        for (int i = 0; i < 64; i++) begin
            cbMem[i] = 9'(cb);
            crMem[i] = 9'(cr);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 256; i++) yMem[i] = 9'($urandom_range(0, 511));
        for (int i = 0; i < 64; i++) begin
            cbMem[i] = 9'($urandom_range(0, 511));
            crMem[i] = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic runMcu(input int bx, input int by, input int w, input int h, input bit gray,
                          input int iw, input int ih, input int abortAt);
        int n, exp0, beatMark;
        n = 64 * w * h;
        expQ.delete();
        beats.delete();
        for (int yy = 0; yy < 8 * h; yy++) begin
            for (int xx = 0; xx < 8 * w; xx++) begin
                int gx, gy, ci;
                gx = bx * 8 * w + xx;
                gy = by * 8 * h + yy;
                ci = (yy >> (h - 1)) * 8 + (xx >> (w - 1));
                if (gx < iw && gy < ih)
                    expQ.push_back(modelPix(gx, gy, int'(yMem[yy * 16 + xx]),
                                            gray ? 0 : int'(cbMem[ci]), gray ? 0 : int'(crMem[ci])));
            end
        end
        exp0 = expQ.size();
        @(negedge clk);
        curW = w; curH = h; curN = n; readIdx = 0; seenValid = 0;
        InBlockX = BLK_W'(bx);
        InBlockY = BLK_W'(by);
        SubSamplingW = 2'(w);
        SubSamplingH = 2'(h);
        InGray = gray;
        ImageWidth = PIX_W'(iw);
        ImageHeight = PIX_W'(ih);
        InEnable = 1'b1;
        @(negedge clk);
        InEnable = 1'b0;
        if (abortAt >= 0) begin
            for (int i = 0; i < 2000 && readIdx < abortAt; i++) begin
                @(negedge clk);
                #2;
            end
            chk("reads before reset", readIdx, abortAt);
            rst = 1'b1;
            @(negedge clk);
            #2;
            chk("outputs zero after reset",
                {OutValid, InRead, InReadNext, OutPixelX, OutPixelY, OutR, OutG, OutB}, 0);
            rst = 1'b0;
            expQ.delete();
            beatMark = beatCnt;
            repeat (12) @(negedge clk);
            #2;
            chk("beats after reset", beatCnt - beatMark, 0);
        end else begin
            for (int i = 0; i < 3000 && !(readIdx >= n && expQ.size() == 0); i++) begin
                @(negedge clk);
                #2;
            end
            repeat (8) @(negedge clk);
            #2;
            chk("reads per MCU", readIdx, n);
            chk("beats per MCU", beats.size(), exp0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        pix_t p;
        int   diffs, maxX;

        // Pin the model against hand-computed colours
        p = modelPix(0, 0, 0, 0, 0);
        chk("model grey R", p.r, 128);
        chk("model grey G", p.g, 128);
        chk("model grey B", p.b, 128);
        p = modelPix(0, 0, 127, 0, 127);
        chk("model sat R", p.r, 255);
        chk("model sat G", p.g, 164);
        chk("model sat B", p.b, 255);
        p = modelPix(0, 0, -128, 0, 0);
        chk("model black", p.r + p.g + p.b, 0);

        fillConst(0, 0, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("reset outputs",
            {OutValid, InRead, InReadNext, OutPixelX, OutPixelY, OutR, OutG, OutB}, 0);
        rst = 1'b0;

        // 4:4:4 neutral grey
        runMcu(0, 0, 1, 1, 0, 1000, 1000, -1);
        chk("first valid latency", firstValidCyc - firstReadCyc, 4);
        chk("grey first R", getBeat(0).r, 128);
        chk("grey first X", getBeat(0).x, 0);
        chk("grey first Y", getBeat(0).y, 0);
        chk("grey last X", getBeat(63).x, 7);
        chk("grey last Y", getBeat(63).y, 7);

        // Saturation
        fillConst(127, 0, 127);
        runMcu(0, 0, 1, 1, 0, 1000, 1000, -1);
        chk("sat R", getBeat(10).r, 255);
        chk("sat G", getBeat(10).g, 164);
        chk("sat B", getBeat(10).b, 255);
        fillConst(-128, 0, 0);
        runMcu(0, 0, 1, 1, 0, 1000, 1000, -1);
        chk("black RGB", getBeat(5).r + getBeat(5).g + getBeat(5).b, 0);

        // 4:2:0 addressing, then the same MCU under random backpressure
        fillRandom();
        runMcu(1, 2, 2, 2, 0, 1000, 1000, -1);
        chk("420 addr Y px5 py9", addrYLog[149], 8'h95);
        chk("420 addr CbCr px5 py9", addrCLog[149], 6'h22);
        chk("420 coord X", getBeat(149).x, 21);
        chk("420 coord Y", getBeat(149).y, 41);
        refBeats = beats;
        randReady = 1;
        runMcu(1, 2, 2, 2, 0, 1000, 1000, -1);
        randReady = 0;
        diffs = 0;
        for (int i = 0; i < refBeats.size() && i < beats.size(); i++)
            if (refBeats[i] != beats[i]) diffs++;
        chk("stalled sequence size", beats.size(), refBeats.size());
        chk("stalled sequence diffs", diffs, 0);

        // Other modes: 4:2:2 greyscale, 4:4:0 with backpressure
        fillRandom();
        runMcu(3, 1, 2, 1, 1, 1000, 1000, -1);
        randReady = 1;
        runMcu(2, 5, 1, 2, 0, 1000, 1000, -1);
        randReady = 0;

        // Edge clipping
        fillRandom();
        runMcu(0, 0, 2, 1, 0, 12, 8, -1);
        chk("clip beats", beats.size(), 96);
        maxX = 0;
        foreach (beats[i]) if (beats[i].x > maxX) maxX = beats[i].x;
        chk("clip max X", maxX, 11);

        // Reset mid-MCU, then a clean restart
        fillRandom();
        runMcu(0, 0, 2, 2, 0, 1000, 1000, 30);
        runMcu(0, 0, 1, 1, 0, 1000, 1000, -1);
        chk("restart first X", getBeat(0).x, 0);
        chk("restart first Y", getBeat(0).y, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
